// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the pipeline memory stage
//   (port A) and the debug/program-loader port (port B). Stores complete in
//   the issue cycle. A load keeps the port for MEM_LAT cycles, then pulses
//   the owner's rvalid. B gets priority over A once it has been denied
//   MAX_WAIT consecutive cycles.
//
// Ports
//   clk, srst                    clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata    pipeline request (held until done)
//   a_rdata/a_rvalid             pipeline load data and valid pulse
//   stall_m                      freezes the pipeline through the memory stage
//   b_req/b_we/b_addr/b_wdata    debug/loader request (held until done)
//   b_gnt                        one-cycle pulse on the B issue cycle
//   b_rdata/b_rvalid             debug/loader load data and valid pulse
//   mem_we/mem_addr/mem_wd       data_memory control, address and write data
//   mem_rd                       data_memory read data
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  output logic              stall_m,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state;
  logic              owner;     // 1 = outstanding read belongs to B
  logic [1:0]        lat_cnt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;    // last issued address, held while idle or waiting
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic grant_a;
  logic grant_b;
  logic rd_done;

  // Arbitration: only in IDLE, suppressed while reset is asserted so the
  // memory port is quiet during the reset cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!srst && state == IDLE) begin
      if (b_req && (!a_req || wait_cnt == WAIT_MAX))
        grant_b = 1'b1;
      else if (a_req)
        grant_a = 1'b1;
    end
  end

  assign rd_done  = !srst && state == WAIT && lat_cnt == 2'd0;
  assign a_rvalid = rd_done & ~owner;
  assign b_rvalid = rd_done &  owner;
  assign b_gnt    = grant_b;

  assign mem_we   = (grant_a & a_we) | (grant_b & b_we);
  assign mem_addr = grant_a ? a_addr  : (grant_b ? b_addr  : addr_q);
  assign mem_wd   = grant_a ? a_wdata : (grant_b ? b_wdata : wd_q);

  // Read data passes straight through on the valid cycle, then holds.
  assign a_rdata  = a_rvalid ? mem_rd : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_rd : b_rdata_q;

  // An A store finishes in its grant cycle and an A load finishes on its
  // rvalid cycle; every other cycle with a_req high must stall.
  assign stall_m  = !srst & a_req & ~(grant_a & a_we) & ~a_rvalid;

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_cnt   <= 2'd0;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      wd_q      <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (grant_a || grant_b) begin
        addr_q <= mem_addr;
        wd_q   <= mem_wd;
      end
      if (a_rvalid)
        a_rdata_q <= mem_rd;
      if (b_rvalid)
        b_rdata_q <= mem_rd;

      // Starvation counter also runs while a read is outstanding.
      if (grant_b)
        wait_cnt <= 4'd0;
      else if (b_req && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 4'd1;

      case (state)
        IDLE: begin
          if ((grant_a && !a_we) || (grant_b && !b_we)) begin
            state   <= WAIT;
            owner   <= grant_b;
            lat_cnt <= LAT_INIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 2'd0)
            state <= IDLE;
          else
            lat_cnt <= lat_cnt - 2'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t qa1[$];
  exp_t qb1[$];
  exp_t qa3[$];
  exp_t qb3[$];

  // Instance with MEM_LAT = 1
  logic        srst, a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wd, mem_rd;
  logic        a_rvalid, b_rvalid, stall_m, b_gnt, mem_we;

  // Instance with MEM_LAT = 3
  logic        srst_3, a_req_3, a_we_3, b_req_3, b_we_3;
  logic [31:0] a_addr_3, a_wdata_3, b_addr_3, b_wdata_3;
  logic [31:0] a_rdata_3, b_rdata_3, mem_addr_3, mem_wd_3, mem_rd_3;
  logic        a_rvalid_3, b_rvalid_3, stall_3, b_gnt_3, mem_we_3;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(4)) u1 (
    .clk(clk), .srst(srst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid), .stall_m(stall_m),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(4)) u3 (
    .clk(clk), .srst(srst_3),
    .a_req(a_req_3), .a_we(a_we_3), .a_addr(a_addr_3), .a_wdata(a_wdata_3),
    .a_rdata(a_rdata_3), .a_rvalid(a_rvalid_3), .stall_m(stall_3),
    .b_req(b_req_3), .b_we(b_we_3), .b_addr(b_addr_3), .b_wdata(b_wdata_3),
    .b_gnt(b_gnt_3), .b_rdata(b_rdata_3), .b_rvalid(b_rvalid_3),
    .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wd(mem_wd_3), .mem_rd(mem_rd_3)
  );

  // Memory models: the arbiter holds the read address for the whole
  // latency, so a combinational read of the current address is enough.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem1[8'h10] <= 32'hDEADBEEF;
      mem3[8'h08] <= 32'hB0B0B0B0;
      mem3[8'h0C] <= 32'hA0A0A0A0;
    end else begin
      if (mem_we)   mem1[mem_addr[7:0]]   <= mem_wd;
      if (mem_we_3) mem3[mem_addr_3[7:0]] <= mem_wd_3;
    end
  end

  assign mem_rd   = mem1[mem_addr[7:0]];
  assign mem_rd_3 = mem3[mem_addr_3[7:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expected
  // read for that port, both in data and in the cycle it appears.
  exp_t e_mon;
  always @(negedge clk) begin
    if (a_rvalid) begin
      if (qa1.size() == 0) chk1("a1_unexpected_rvalid", 1'b1, 1'b0);
      else begin
        e_mon = qa1.pop_front();
        check("a1_rdata", a_rdata, e_mon.data);
        check("a1_rvalid_cycle", cyc, e_mon.cycle);
      end
    end
    if (b_rvalid) begin
      if (qb1.size() == 0) chk1("b1_unexpected_rvalid", 1'b1, 1'b0);
      else begin
        e_mon = qb1.pop_front();
        check("b1_rdata", b_rdata, e_mon.data);
        check("b1_rvalid_cycle", cyc, e_mon.cycle);
      end
    end
    if (a_rvalid_3) begin
      if (qa3.size() == 0) chk1("a3_unexpected_rvalid", 1'b1, 1'b0);
      else begin
        e_mon = qa3.pop_front();
        check("a3_rdata", a_rdata_3, e_mon.data);
        check("a3_rvalid_cycle", cyc, e_mon.cycle);
      end
    end
    if (b_rvalid_3) begin
      if (qb3.size() == 0) chk1("b3_unexpected_rvalid", 1'b1, 1'b0);
      else begin
        e_mon = qb3.pop_front();
        check("b3_rdata", b_rdata_3, e_mon.data);
        check("b3_rvalid_cycle", cyc, e_mon.cycle);
      end
    end
  end

  initial begin
    srst = 1'b1; a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0;
    a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
    srst_3 = 1'b1; a_req_3 = 1'b0; a_we_3 = 1'b0; b_req_3 = 1'b0; b_we_3 = 1'b0;
    a_addr_3 = '0; a_wdata_3 = '0; b_addr_3 = '0; b_wdata_3 = '0;

    // Reset
    repeat (2) begin
      next; smp;
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_stall", stall_m, 1'b0);
      chk1("rst_b_gnt", b_gnt, 1'b0);
    end
    next; srst = 1'b0; srst_3 = 1'b0; smp;
    chk1("post_rst_a_rvalid", a_rvalid, 1'b0);
    chk1("post_rst_b_rvalid", b_rvalid, 1'b0);
    check("post_rst_mem_addr", mem_addr, 32'h0);
    check("post_rst_mem_wd", mem_wd, 32'h0);
    check("post_rst_a_rdata", a_rdata, 32'h0);
    check("post_rst_b_rdata", b_rdata, 32'h0);

    // Idle bus for 10 cycles
    for (int i = 0; i < 10; i++) begin
      next; smp;
      chk1("idle_mem_we", mem_we, 1'b0);
      chk1("idle_stall", stall_m, 1'b0);
      check("idle_wait_cnt", 32'(u1.wait_cnt), 32'h0);
    end

    // A load of 0x10, MEM_LAT = 1
    next; a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    qa1.push_back('{32'hDEADBEEF, cyc + 1});
    smp;
    chk1("t1_issue_stall", stall_m, 1'b1);
    check("t1_issue_addr", mem_addr, 32'h10);
    chk1("t1_issue_we", mem_we, 1'b0);
    next; smp;
    chk1("t1_rvalid_stall", stall_m, 1'b0);
    chk1("t1_rvalid", a_rvalid, 1'b1);
    next; a_req = 1'b0; smp;
    chk1("t1_after_rvalid", a_rvalid, 1'b0);
    check("t1_rdata_hold", a_rdata, 32'hDEADBEEF);

    // A store 0x1234 to 0x20, then load it back
    next; a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234; smp;
    chk1("t2_store_we", mem_we, 1'b1);
    check("t2_store_addr", mem_addr, 32'h20);
    check("t2_store_wd", mem_wd, 32'h1234);
    chk1("t2_store_stall", stall_m, 1'b0);
    next; a_req = 1'b0; smp;
    chk1("t2_store_we_off", mem_we, 1'b0);
    check("t2_addr_hold", mem_addr, 32'h20);
    chk1("t2_idle_stall", stall_m, 1'b0);
    next; a_req = 1'b1; a_we = 1'b0; a_addr = 32'h20;
    qa1.push_back('{32'h1234, cyc + 1});
    smp;
    chk1("t2_load_stall", stall_m, 1'b1);
    next; smp;
    chk1("t2_rvalid_stall", stall_m, 1'b0);
    next; a_req = 1'b0;

    // Starvation: A stores every cycle, B store waiting
    next;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h30; a_wdata = 32'h55;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next;
      smp;
      chk1("t3_deny_gnt", b_gnt, 1'b0);
      chk1("t3_a_store_we", mem_we, 1'b1);
      check("t3_a_store_addr", mem_addr, 32'h30);
      chk1("t3_a_store_stall", stall_m, 1'b0);
    end
    next; smp;
    chk1("t3_b_gnt", b_gnt, 1'b1);
    check("t3_b_addr", mem_addr, 32'h40);
    check("t3_b_wd", mem_wd, 32'h77);
    chk1("t3_b_gnt_stall", stall_m, 1'b1);
    next; b_req = 1'b0; smp;
    check("t3_wait_cnt_clear", 32'(u1.wait_cnt), 32'h0);
    chk1("t3_after_gnt", b_gnt, 1'b0);
    chk1("t3_after_stall", stall_m, 1'b0);
    next; a_req = 1'b0;
    // B reads back its own store
    next; b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40;
    qb1.push_back('{32'h77, cyc + 1});
    smp;
    chk1("t3_b_load_gnt", b_gnt, 1'b1);
    chk1("t3_b_load_we", mem_we, 1'b0);
    next; smp;
    next; b_req = 1'b0; smp;
    chk1("t3_b_rvalid_off", b_rvalid, 1'b0);
    check("t3_b_rdata_hold", b_rdata, 32'h77);

    // MEM_LAT = 3: B load, then A load queued behind it
    next; b_req_3 = 1'b1; b_we_3 = 1'b0; b_addr_3 = 32'h08;
    qb3.push_back('{32'hB0B0B0B0, cyc + 3});
    smp;
    chk1("t4_b_gnt", b_gnt_3, 1'b1);
    chk1("t4_b_issue_stall", stall_3, 1'b0);
    next; a_req_3 = 1'b1; a_we_3 = 1'b0; a_addr_3 = 32'h0C; smp;
    chk1("t4_wait_stall", stall_3, 1'b1);
    chk1("t4_wait_gnt", b_gnt_3, 1'b0);
    check("t4_wait_addr", mem_addr_3, 32'h08);
    chk1("t4_wait_we", mem_we_3, 1'b0);
    next; smp;
    chk1("t4_wait_stall", stall_3, 1'b1);
    next; smp;
    chk1("t4_b_rvalid_stall", stall_3, 1'b1);
    next; b_req_3 = 1'b0;
    qa3.push_back('{32'hA0A0A0A0, cyc + 3});
    smp;
    chk1("t4_a_issue_stall", stall_3, 1'b1);
    check("t4_a_issue_addr", mem_addr_3, 32'h0C);
    for (int i = 0; i < 2; i++) begin
      next; smp;
      chk1("t4_a_wait_stall", stall_3, 1'b1);
    end
    next; smp;
    chk1("t4_a_rvalid_stall", stall_3, 1'b0);
    next; a_req_3 = 1'b0; smp;
    check("t4_a_rdata_hold", a_rdata_3, 32'hA0A0A0A0);

    // Reset while a read is outstanding
    next; a_req_3 = 1'b1; a_we_3 = 1'b0; a_addr_3 = 32'h08; smp;
    chk1("t5_issue_stall", stall_3, 1'b1);
    next; srst_3 = 1'b1; a_req_3 = 1'b0; smp;
    chk1("t5_rst_stall", stall_3, 1'b0);
    chk1("t5_rst_rvalid", a_rvalid_3, 1'b0);
    next; srst_3 = 1'b0; smp;
    check("t5_state_idle", 32'(u3.state), 32'h0);
    chk1("t5_mem_we", mem_we_3, 1'b0);
    check("t5_mem_addr", mem_addr_3, 32'h0);
    check("t5_mem_wd", mem_wd_3, 32'h0);
    check("t5_a_rdata", a_rdata_3, 32'h0);
    check("t5_b_rdata", b_rdata_3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      next; smp;
      chk1("t5_no_a_rvalid", a_rvalid_3, 1'b0);
      chk1("t5_no_b_rvalid", b_rvalid_3, 1'b0);
    end
    // Fresh load after reset still works
    next; a_req_3 = 1'b1; a_we_3 = 1'b0; a_addr_3 = 32'h08;
    qa3.push_back('{32'hB0B0B0B0, cyc + 3});
    repeat (3) next;
    next; a_req_3 = 1'b0;
    repeat (3) next;

    smp;
    check("end_qa1_empty", 32'(qa1.size()), 32'h0);
    check("end_qb1_empty", 32'(qb1.size()), 32'h0);
    check("end_qa3_empty", 32'(qa3.size()), 32'h0);
    check("end_qb3_empty", 32'(qb3.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
